// File: rtl/int_ctrl.sv
// Four-source interrupt controller: level/edge capture into pending bits and
// fixed lowest-index-first arbitration, presented to the CPU with an irq/ack handshake.
module int_ctrl #(
  parameter int                 NUM_SRC   = 4,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = 4'b0000
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_SRC-1:0] src_req,
  output logic [NUM_SRC-1:0] src_ack,
  input  logic [NUM_SRC-1:0] en_mask,
  output logic               irq,
  output logic [1:0]         irq_id,
  input  logic               cpu_ack,
  output logic [NUM_SRC-1:0] pend,
  output logic [1:0]         dbg_state
);

  // Handshake: irq stays high with a stable irq_id until the CPU pulses
  // cpu_ack for one cycle; src_ack[irq_id] then pulses exactly one cycle later.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  state_e             state_q;
  logic [NUM_SRC-1:0] req_q, req_qq;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] blocked_q, blocked_d;
  logic               irq_q;
  logic [1:0]         irq_id_q;
  logic [NUM_SRC-1:0] src_ack_q;

  logic [NUM_SRC-1:0] clr, set_lvl, set_edge, arb;
  logic [1:0]         win_id;

  always_comb begin
    clr = '0;
    if (state_q == S_REQ && cpu_ack) clr[irq_id_q] = 1'b1;
    // A level source being acked must not re-pend on the same edge; an edge source may.
    set_lvl   = req_q & ~blocked_q & ~clr;
    set_edge  = req_q & ~req_qq;
    pend_d    = (pend_q & ~clr) | (EDGE_MASK & set_edge) | (~EDGE_MASK & set_lvl);
    blocked_d = ~EDGE_MASK & req_q & (blocked_q | clr);
    arb       = pend_q & en_mask;
    win_id    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (arb[i]) win_id = 2'(i);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_q     <= '0;
      req_qq    <= '0;
      pend_q    <= '0;
      blocked_q <= '0;
    end else begin
      req_q     <= src_req;
      req_qq    <= req_q;
      pend_q    <= pend_d;
      blocked_q <= blocked_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      irq_q     <= 1'b0;
      irq_id_q  <= '0;
      src_ack_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          src_ack_q <= '0;
          if (|arb) begin
            state_q  <= S_REQ;
            irq_q    <= 1'b1;
            irq_id_q <= win_id;
          end
        end
        S_REQ: begin
          if (cpu_ack) begin
            state_q   <= S_ACK;
            irq_q     <= 1'b0;
            src_ack_q <= clr;
          end else if (!en_mask[irq_id_q]) begin
            state_q <= S_IDLE;
            irq_q   <= 1'b0;
          end
        end
        S_ACK: begin
          state_q   <= S_IDLE;
          irq_q     <= 1'b0;
          src_ack_q <= '0;
        end
        default: begin
          state_q   <= S_IDLE;
          irq_q     <= 1'b0;
          src_ack_q <= '0;
        end
      endcase
    end
  end

  assign src_ack   = src_ack_q;
  assign irq       = irq_q;
  assign irq_id    = irq_id_q;
  assign pend      = pend_q;
  assign dbg_state = state_q;

endmodule
